// File: rtl/odd_div_clk_monitor.sv
// odd_div_clk_monitor
// Lock/frequency monitor for the odd-ratio clock divider output.
// clk_mon is sampled as asynchronous data in the clk_in domain.
// Every rising-edge-to-rising-edge spacing is measured in clk_in cycles.
// The monitor reports lock after LOCK_COUNT consecutive periods equal to DIVIDOR.
// It raises a sticky fault when edges stop arriving.
module odd_div_clk_monitor #(
  parameter int DIVIDOR    = 5,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_mon,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [7:0]       err_cnt
);

  localparam int MCNT_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  localparam logic [CNT_W-1:0]  DIV_C   = CNT_W'(DIVIDOR);
  localparam logic [CNT_W-1:0]  TO_C    = CNT_W'(TIMEOUT);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(LOCK_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ACQ,
    LOCKED,
    FAULT
  } state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic [CNT_W-1:0]  cnt;
  logic [MCNT_W-1:0] mcnt;

  logic rise;
  logic timeout;
  logic match;

  assign rise    = s2 & ~s3;
  assign timeout = (cnt == TO_C);
  assign match   = (cnt == DIV_C);

  // Two-flop synchronizer on clk_mon plus a delay flop for edge detection.
  // NOTE: s1 can go metastable; only s2/s3 are consumed by logic, never s1.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop captures the previous stage's old value.
      s1 <= clk_mon;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Period counter: restarts at 1 on each rise and saturates at TIMEOUT.
  // It is held at 0 while idle or faulted.
  always_ff @(posedge clk_in) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (state == IDLE || state == FAULT) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != TO_C) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Monitor FSM with the match counter, published period and error count.
  // A rise wins over a timeout in the same cycle; en low wins over everything.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      mcnt       <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      period_vld <= 1'b0;
      if (!en) begin
        state <= IDLE;
        mcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
          end

          // The first edge only provides the reference; no period is reported.
          ARM: begin
            if (rise) begin
              state <= ACQ;
            end else if (timeout) begin
              state <= FAULT;
            end
          end

          ACQ: begin
            if (rise) begin
              period     <= cnt;
              period_vld <= 1'b1;
              if (match) begin
                if (mcnt == MCNT_LAST) begin
                  state <= LOCKED;
                  mcnt  <= '0;
                end else begin
                  mcnt <= mcnt + MCNT_W'(1);
                end
              end else begin
                mcnt <= '0;
                if (err_cnt != 8'hFF) begin
                  err_cnt <= err_cnt + 8'd1;
                end
              end
            end else if (timeout) begin
              state <= FAULT;
              mcnt  <= '0;
            end
          end

          LOCKED: begin
            if (rise) begin
              period     <= cnt;
              period_vld <= 1'b1;
              if (!match) begin
                state <= ACQ;
                mcnt  <= '0;
                if (err_cnt != 8'hFF) begin
                  err_cnt <= err_cnt + 8'd1;
                end
              end
            end else if (timeout) begin
              state <= FAULT;
              mcnt  <= '0;
            end
          end

          // Sticky until en drops or rst is asserted.
          FAULT: begin
            state <= FAULT;
          end

          default: begin
            state <= IDLE;
            mcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_odd_div_clk_monitor.sv
// Self-checking bench for odd_div_clk_monitor.
// The stimulus drives clk_mon rising edges at chosen spacings.
// For each rise that closes a measured period, it pushes the expected (period, locked, err_cnt) tuple.
// A monitor pops one entry per period_vld pulse and compares.
module tb_odd_div_clk_monitor;

  localparam int DIVIDOR    = 5;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 16;
  localparam int CNT_W      = $clog2(TIMEOUT + 1);

  logic             clk_in;
  logic             rst;
  logic             en;
  logic             clk_mon;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic [7:0]       err_cnt;

  odd_div_clk_monitor #(
    .DIVIDOR   (DIVIDOR),
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .clk_mon   (clk_mon),
    .locked    (locked),
    .fault     (fault),
    .period    (period),
    .period_vld(period_vld),
    .err_cnt   (err_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int period;
    bit locked;
    int err;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Expected-behaviour state, tracked at transaction level.
  int m_mcnt   = 0;
  bit m_locked = 1'b0;
  int m_err    = 0;
  int prev_gap = -1;
  bit report   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input int gap);
    if (gap == DIVIDOR) begin
      if (!m_locked) begin
        if (m_mcnt == LOCK_COUNT - 1) begin
          m_locked = 1'b1;
          m_mcnt   = 0;
        end else begin
          m_mcnt++;
        end
      end
    end else begin
      m_locked = 1'b0;
      m_mcnt   = 0;
      if (m_err < 255) m_err++;
    end
    q.push_back('{period: gap, locked: m_locked, err: m_err});
  endtask

  // en low (or reset) puts the monitor back to re-arming: no reference edge, no matches.
  task automatic model_disarm();
    m_mcnt   = 0;
    m_locked = 1'b0;
    prev_gap = -1;
  endtask

  // Called at a negedge: rise clk_mon now, hold high for hi cycles, then low until gap elapses.
  task automatic pulse(input int gap, input int hi);
    if (report && prev_gap >= 0) sb_push(prev_gap);
    clk_mon = 1'b1;
    repeat (hi) @(negedge clk_in);
    clk_mon = 1'b0;
    repeat (gap - hi) @(negedge clk_in);
    prev_gap = gap;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
    if (prev_gap >= 0) prev_gap += n;
  endtask

  // Scoreboard consumer: one expected entry per period_vld pulse.
  always @(negedge clk_in) begin
    if (period_vld === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_period_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("period", 32'(period), 32'(e.period));
        check("locked_at_vld", 32'(locked), 32'(e.locked));
        check("err_cnt_at_vld", 32'(err_cnt), 32'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    clk_mon = 1'b0;

    // Reset held for two edges with clk_mon toggling.
    @(negedge clk_in);
    clk_mon = 1'b1;
    @(negedge clk_in);
    clk_mon = 1'b0;
    rst     = 1'b0;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_period_vld", 32'(period_vld), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Disabled: edges arrive but nothing is measured and no lock appears.
    report = 1'b0;
    for (int i = 0; i < 6; i++) pulse(5, 2 + (i % 2));
    check("disabled_locked", 32'(locked), 32'd0);
    check("disabled_fault", 32'(fault), 32'd0);

    // Lock on an ideal odd-ratio divider: high phase alternates 2/3 cycles.
    en     = 1'b1;
    report = 1'b1;
    model_disarm();
    idle(2);
    for (int i = 0; i < 6; i++) pulse(5, 2 + (i % 2));
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_err_cnt", 32'(err_cnt), 32'd0);

    // One stretched period drops lock; four good periods relock.
    pulse(6, 3);
    for (int i = 0; i < 5; i++) pulse(5, 3 - (i % 2));
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_err_cnt", 32'(err_cnt), 32'd1);

    // Timeout: clk_mon stops after one more rise.
    // Fault appears on the 17th edge after the rise cycle.
    pulse(2, 2);
    repeat (TIMEOUT) @(negedge clk_in);
    check("timeout_before", 32'(fault), 32'd0);
    @(negedge clk_in);
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_locked", 32'(locked), 32'd0);

    // Fault is sticky when edges resume; only en low clears it.
    report = 1'b0;
    for (int i = 0; i < 3; i++) pulse(5, 2);
    check("fault_sticky", 32'(fault), 32'd1);
    en = 1'b0;
    @(negedge clk_in);
    check("fault_cleared_by_en", 32'(fault), 32'd0);
    check("err_kept_after_en", 32'(err_cnt), 32'(m_err));
    model_disarm();

    // Saturation: alternating 4/6 periods never match and never lock.
    en     = 1'b1;
    report = 1'b1;
    idle(2);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) pulse(4, 2);
      else            pulse(6, 3);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_locked", 32'(locked), 32'd0);

    // Partial acquisition, then a one-cycle en drop: the match count must restart.
    for (int i = 0; i < 3; i++) pulse(5, 2);
    en = 1'b0;
    @(negedge clk_in);
    en = 1'b1;
    model_disarm();
    idle(2);
    for (int i = 0; i < 5; i++) pulse(5, 2 + (i % 2));
    check("en_pulse_relock", 32'(locked), 32'd1);

    // Stall into FAULT, then a single-cycle rst restores reset values.
    idle(20);
    check("fault_before_rst", 32'(fault), 32'd1);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    m_err = 0;
    model_disarm();
    check("rst_fault_fault", 32'(fault), 32'd0);
    check("rst_fault_locked", 32'(locked), 32'd0);
    check("rst_fault_period", 32'(period), 32'd0);
    check("rst_fault_vld", 32'(period_vld), 32'd0);
    check("rst_fault_err_cnt", 32'(err_cnt), 32'd0);

    en = 1'b0;
    idle(4);
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/odd_div_clk_monitor.md
# odd_div_clk_monitor

Frequency/lock monitor placed directly downstream of the odd-ratio clock divider. It samples the divided clock (`clk_mon`) in the source clock domain and measures each period in source-clock cycles. It declares lock after `LOCK_COUNT` consecutive periods equal to `DIVIDOR`, and flags a sticky fault if edges stop arriving. It gives the integration layer a checked "divided clock is good" qualifier before any logic is released onto the divided clock.

## Interface
- `DIVIDOR`, default 5: expected period of `clk_mon` in `clk_in` cycles; legal range ≥ 3.
- `LOCK_COUNT`, default 4: consecutive matching periods required to assert lock; legal range ≥ 1.
- `TIMEOUT`, default 16: cycles without a `clk_mon` rising edge before fault; must be > `DIVIDOR`.
- `CNT_W`, derived as `$clog2(TIMEOUT+1)`: width of the period counter and the `period` output.

Ports:
- `clk_in`  in  1  source clock; the only clock. `clk_mon` is treated as asynchronous data.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable, level-sensitive.
- `clk_mon`  in  1  divided clock under test.
- `locked`  out  1  high while the FSM is in LOCKED.
- `fault`  out  1  high while the FSM is in FAULT.
- `period`  out  `CNT_W`  last measured period.
- `period_vld`  out  1  one-cycle pulse when `period` updates.
- `err_cnt`  out  8  saturating count of mismatched periods.

## Operation
- **Synchronizer:** two flops `s1`, `s2`, then delay flop `s3`. `rise` = `s2 & ~s3`.
- **Period counter `cnt`:**
  - 0 in IDLE and FAULT.
  - Otherwise, on `rise`: `cnt` ← 1.
  - Else: `cnt` ← `cnt` + 1, saturating at `TIMEOUT`.
  - Result: two rises P cycles apart leave `cnt` = P in the second rise cycle.
- **Match counter `mcnt`:** range 0..`LOCK_COUNT`-1, cleared on any mismatch and on leaving ACQ/LOCKED.
- **FSM states:** IDLE, ARM, ACQ, LOCKED, FAULT.
  - Any state with `en`=0 → IDLE. This clears `mcnt` and `cnt`; `err_cnt` is kept.
  - IDLE with `en`=1 → ARM.
  - ARM:
    - `rise` → ACQ. No period is reported because the first edge has no reference.
    - `cnt`==`TIMEOUT` without `rise` → FAULT.
  - ACQ, on `rise`:
    - Publish `period` ← `cnt` and pulse `period_vld`.
    - If `cnt`==`DIVIDOR` and `mcnt`==`LOCK_COUNT`-1 → LOCKED.
    - Else if `cnt`==`DIVIDOR` → `mcnt`+1.
    - Mismatch → `mcnt` ← 0, `err_cnt`+1, stay in ACQ.
  - LOCKED, on `rise`:
    - Publish `period` as in ACQ.
    - Match → stay.
    - Mismatch → ACQ, `mcnt` ← 0, `err_cnt`+1.
  - ACQ/LOCKED: `cnt`==`TIMEOUT` without `rise` → FAULT.
  - FAULT is sticky. It is left only through `en`=0 or `rst`.
- **Simultaneous events:** `rise` takes precedence over timeout in the same cycle. `en`=0 takes precedence over everything.
- **`err_cnt`:** saturates at 255. It is cleared only by `rst`.
- **Output decode:** `locked` and `fault` are decoded from the registered state with no combinational path from inputs. `period` and `period_vld` are registered.

## Timing
- **Reset values:** `locked`=0, `fault`=0, `period`=0, `period_vld`=0, `err_cnt`=0, state IDLE, `s1`/`s2`/`s3`=0, `cnt`=0, `mcnt`=0.
- **`rst` mid-operation:** returns everything to reset values at the next `clk_in` edge, including in LOCKED and FAULT.
- **Edge latency:** `rise` is asserted in the cycle after the second `clk_in` edge that samples `clk_mon` high. `period`, `period_vld` and the state update one `clk_in` edge later, so there are 3 edges from first sample to `period_vld`.
- **Time to lock:** `locked` rises at the `clk_in` edge closing the rise cycle of the `LOCK_COUNT`-th matching period after ARM's first edge. That is (`LOCK_COUNT` × `DIVIDOR`) cycles after the first edge, plus the 3-edge pipeline.
- **Lock loss:** `locked` falls on the same edge that publishes a mismatching `period`.
- **Timeout:** `fault` rises on the edge following the cycle in which `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT`+1 edges after the last rise cycle.
- **Odd-ratio duty cycle:** sampling may see the high phase as ⌊`DIVIDOR`/2⌋ or ⌈`DIVIDOR`/2⌉ cycles. Rising-edge spacing is still exactly `DIVIDOR`, so no mismatch results.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `clk_mon` toggling → all outputs 0, `locked` stays 0 while `en`=0.
- **Lock:** `en`=1, `clk_mon` = ideal divide-by-5 (2.5/2.5 duty) → `period_vld` pulses every 5 cycles with `period`=5; `locked`=1 after the 4th matching period, `err_cnt`=0.
- **Mismatch:** from LOCKED, stretch one `clk_mon` period to 6 → `period`=6, `locked`=0 on that edge, `err_cnt`=1; relocks after 4 further period-5 edges.
- **Timeout:** from LOCKED, hold `clk_mon`=0 → `fault`=1 exactly 17 edges after the last rise cycle; `fault` stays 1 after `clk_mon` resumes; deassert `en` → `fault`=0 next edge, `err_cnt` unchanged.
- **Saturation:** alternate periods 4/6 for 300 edges → `err_cnt` saturates at 255, `locked` never asserts.
- **Mid-operation control:** in ACQ, pulse `en` low 1 cycle → IDLE, `mcnt` cleared, full relock sequence needed; separately, `rst` in FAULT → reset values next edge.
